// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

    // Number of WORD_W-wide words needed to cover a chain of chain_len bits.
    function automatic int unsigned words_for(input int unsigned chain_len,
                                              input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_readback_packer.sv
// Collects the serial tail bits (first bit ends up in the MSB) into
// WORD_W-wide readback words with a one-word valid/ready output slot.
module ccff_readback_packer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic              flush,
    output logic              can_accept,
    output logic              drained,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready
);
    localparam int FILL_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] acc;
    logic [FILL_W-1:0] fill;
    logic [WORD_W-1:0] acc_next;
    logic [FILL_W-1:0] pad;
    logic              slot_free;
    logic              last_bit;

    assign slot_free  = !rb_valid || rb_ready;
    assign last_bit   = (fill == FILL_W'(WORD_W - 1));
    // A bit is refused only when it would complete a word while the slot is stuck.
    assign can_accept = !last_bit || slot_free;
    assign drained    = (fill == '0) && slot_free;
    assign acc_next   = (acc << 1) | WORD_W'(bit_in);
    assign pad        = FILL_W'(WORD_W) - fill;

    // Accumulate tail bits, hand off full or flushed partial words to the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            fill     <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            if (rb_valid && rb_ready) begin
                rb_valid <= 1'b0;
            end
            if (bit_en && can_accept) begin
                if (last_bit) begin
                    rb_data  <= acc_next;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    fill     <= '0;
                end else begin
                    acc  <= acc_next;
                    fill <= fill + FILL_W'(1);
                end
            end else if (flush && (fill != '0) && slot_free) begin
                // Partial word: left-align so the first bit sits in the MSB.
                rb_data  <= acc << pad;
                rb_valid <= 1'b1;
                acc      <= '0;
                fill     <= '0;
            end
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words MSB-first into the configuration chain head,
// gating the chain clock one bit at a time, while repacking the old chain
// contents emerging from the tail into readback words.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);
    localparam int WB_W = $clog2(WORD_W + 1);

    loader_state_e     state;
    logic [CNT_W-1:0]  bits_left;
    logic [WB_W-1:0]   word_bits;
    logic [WORD_W-1:0] shreg;
    logic              rb_can_accept;
    logic              rb_drained;

    assign prog_clk_en = (state == ST_SHIFT) && rb_can_accept;
    assign ccff_head   = (state == ST_SHIFT) && shreg[WORD_W-1];
    assign cfg_ready   = (state == ST_FETCH);
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);

    ccff_readback_packer #(
        .WORD_W(WORD_W)
    ) u_packer (
        .clk       (prog_clk),
        .reset     (prog_reset),
        .bit_en    (prog_clk_en),
        .bit_in    (ccff_tail),
        .flush     (state == ST_FLUSH),
        .can_accept(rb_can_accept),
        .drained   (rb_drained),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
        .rb_ready  (rb_ready)
    );

    // Load sequencer: fetch a word, shift its valid bits, repeat, then drain readback.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= ST_IDLE;
            bits_left <= '0;
            word_bits <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bits_left <= CNT_W'(CHAIN_LEN);
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (cfg_valid) begin
                        shreg <= cfg_data;
                        if (32'(bits_left) >= 32'(WORD_W)) begin
                            word_bits <= WB_W'(WORD_W);
                        end else begin
                            word_bits <= WB_W'(bits_left);
                        end
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (prog_clk_en) begin
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - CNT_W'(1);
                        word_bits <= word_bits - WB_W'(1);
                        // Chain end takes priority; any unshifted low bits are dropped.
                        if (bits_left == CNT_W'(1)) begin
                            state <= ST_FLUSH;
                        end else if (word_bits == WB_W'(1)) begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (rb_drained) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (40-bit and 64-bit chains)
// driven against a behavioural chain model; expectations come from simple
// bit-string arithmetic on the preload and the written words.
module tb_ccff_bitstream_loader;
    import ccff_loader_pkg::*;

    localparam int WORD_W = 32;
    localparam int LEN0   = 40;
    localparam int LEN1   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   prog_reset;
    logic [1:0]             start_s, cfg_valid_s, cfg_ready_s, head_s, en_s, tail_s;
    logic [1:0]             rb_valid_s, rb_ready_s, busy_s, done_s;
    logic [1:0][WORD_W-1:0] cfg_data_s, rb_data_s;

    ccff_bitstream_loader #(.CHAIN_LEN(LEN0), .WORD_W(WORD_W)) dut0 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[0]),
        .cfg_data(cfg_data_s[0]), .cfg_valid(cfg_valid_s[0]), .cfg_ready(cfg_ready_s[0]),
        .ccff_head(head_s[0]), .prog_clk_en(en_s[0]), .ccff_tail(tail_s[0]),
        .rb_data(rb_data_s[0]), .rb_valid(rb_valid_s[0]), .rb_ready(rb_ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0])
    );

    ccff_bitstream_loader #(.CHAIN_LEN(LEN1), .WORD_W(WORD_W)) dut1 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[1]),
        .cfg_data(cfg_data_s[1]), .cfg_valid(cfg_valid_s[1]), .cfg_ready(cfg_ready_s[1]),
        .ccff_head(head_s[1]), .prog_clk_en(en_s[1]), .ccff_tail(tail_s[1]),
        .rb_data(rb_data_s[1]), .rb_valid(rb_valid_s[1]), .rb_ready(rb_ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1])
    );

    // Chain model: a shift register of the chain length, head enters at bit 0.
    logic [1:0][63:0]       chain;
    logic [1:0]             pre_load;
    logic [1:0][63:0]       pre_val;
    int                     en_cnt[2], done_cnt[2], in_hs[2], stab_err[2];
    logic [WORD_W-1:0]      rbq0[$], rbq1[$];
    logic [1:0]             pend;
    logic [1:0][WORD_W-1:0] pend_data;
    logic                   prev_rst;

    assign tail_s[0] = chain[0][LEN0-1];
    assign tail_s[1] = chain[1][LEN1-1];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pre_load[i]) begin
                chain[i]    <= pre_val[i];
                en_cnt[i]   <= 0;
                done_cnt[i] <= 0;
                in_hs[i]    <= 0;
                stab_err[i] <= 0;
                if (i == 0) rbq0.delete(); else rbq1.delete();
            end else begin
                if (en_s[i]) begin
                    chain[i]  <= {chain[i][62:0], head_s[i]};
                    en_cnt[i] <= en_cnt[i] + 1;
                end
                if (done_s[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (cfg_valid_s[i] && cfg_ready_s[i] && !prog_reset) in_hs[i] <= in_hs[i] + 1;
                if (rb_valid_s[i] && rb_ready_s[i] && !prog_reset) begin
                    if (i == 0) rbq0.push_back(rb_data_s[i]); else rbq1.push_back(rb_data_s[i]);
                end
                if (!prev_rst && pend[i] && (!rb_valid_s[i] || rb_data_s[i] != pend_data[i]))
                    stab_err[i] <= stab_err[i] + 1;
            end
            pend[i]      <= rb_valid_s[i] && !rb_ready_s[i];
            pend_data[i] <= rb_data_s[i];
        end
        prev_rst <= prog_reset;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int rb_count(input int i);
        return (i == 0) ? rbq0.size() : rbq1.size();
    endfunction

    function automatic logic [WORD_W-1:0] rb_word(input int i, input int k);
        if (i == 0) return (k < rbq0.size()) ? rbq0[k] : '0;
        return (k < rbq1.size()) ? rbq1[k] : '0;
    endfunction

    // Full load on instance i with optional input gap, readback hold and mid-load start.
    task automatic run_load(input string tag, input int i, input logic [63:0] pre,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [63:0] exp_chain, input logic [31:0] exp_rb0,
                            input logic [31:0] exp_rb1, input int gap, input int hold,
                            input int restart_at, input bit rnd);
        int len, cyc, wi, gap_done, gap_en, hold_done, hold_en, en_hold_end, nwords;
        bit timeout, hs, hold_armed, restarted;
        logic [63:0] mask;
        len = (i == 0) ? LEN0 : LEN1;
        nwords = int'(words_for(len, WORD_W));
        mask = '1;
        mask = mask >> (64 - len);
        @(negedge clk);
        pre_load[i] = 1'b1; pre_val[i] = pre;
        @(negedge clk);
        pre_load[i] = 1'b0; start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        check({tag, ":busy"}, 64'(busy_s[i]), 64'd1);
        cyc = 0; wi = 0; gap_done = 0; gap_en = 0; hold_done = 0; hold_en = 0;
        en_hold_end = -1; timeout = 1'b0; hold_armed = 1'b0; restarted = 1'b0;
        while (!done_s[i]) begin
            if (cyc >= 3000) begin timeout = 1'b1; break; end
            cfg_data_s[i] = (wi == 0) ? w0 : w1;
            if (wi >= nwords) cfg_valid_s[i] = 1'b0;
            else if (wi == 1 && gap_done < gap) cfg_valid_s[i] = 1'b0;
            else if (rnd) cfg_valid_s[i] = ($urandom_range(0, 3) != 0);
            else cfg_valid_s[i] = 1'b1;
            if (wi == 1 && gap_done < gap && cfg_ready_s[i]) begin
                gap_done++;
                if (en_s[i]) gap_en++;
            end
            if (hold > 0 && rb_valid_s[i]) hold_armed = 1'b1;
            if (hold_armed && hold_done < hold) begin
                rb_ready_s[i] = 1'b0;
                if (en_cnt[i] >= len - 1) begin
                    hold_done++;
                    if (en_s[i]) hold_en++;
                    if (hold_done == hold) en_hold_end = en_cnt[i];
                end
            end else if (rnd) rb_ready_s[i] = ($urandom_range(0, 2) != 0);
            else rb_ready_s[i] = 1'b1;
            start_s[i] = 1'b0;
            if (restart_at > 0 && !restarted && en_cnt[i] == restart_at) begin
                start_s[i] = 1'b1;
                restarted = 1'b1;
            end
            hs = cfg_valid_s[i] && cfg_ready_s[i];
            @(negedge clk);
            if (hs) wi++;
            cyc++;
        end
        cfg_valid_s[i] = 1'b0; rb_ready_s[i] = 1'b1; start_s[i] = 1'b0;
        check({tag, ":timeout"}, 64'(timeout), 64'd0);
        @(negedge clk);
        check({tag, ":done_cnt"},  64'(done_cnt[i]), 64'd1);
        check({tag, ":idle"},      {62'd0, busy_s[i], done_s[i]}, 64'd0);
        check({tag, ":en_cycles"}, 64'(en_cnt[i]), 64'(len));
        check({tag, ":in_hs"},     64'(in_hs[i]), 64'(nwords));
        check({tag, ":rb_count"},  64'(rb_count(i)), 64'(nwords));
        check({tag, ":rb0"},       64'(rb_word(i, 0)), 64'(exp_rb0));
        check({tag, ":rb1"},       64'(rb_word(i, 1)), 64'(exp_rb1));
        check({tag, ":chain"},     chain[i] & mask, exp_chain);
        check({tag, ":rb_stable"}, 64'(stab_err[i]), 64'd0);
        if (gap > 0) begin
            check({tag, ":gap_seen"}, 64'(gap_done), 64'(gap));
            check({tag, ":gap_en"},   64'(gap_en), 64'd0);
        end
        if (hold > 0) begin
            check({tag, ":hold_en"},  64'(hold_en), 64'd0);
            check({tag, ":hold_pos"}, 64'(en_hold_end), 64'(len - 1));
        end
        if (timeout) begin
            prog_reset = 1'b1;
            repeat (2) @(negedge clk);
            prog_reset = 1'b0;
        end
    endtask

    typedef struct {
        string       tag;
        int          inst;
        logic [63:0] pre;
        logic [31:0] w0, w1;
        int          gap, hold, restart_at;
        logic [63:0] exp_chain;
        logic [31:0] exp_rb0, exp_rb1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, inst, len;
        logic [63:0] pre, left, exp_chain;
        logic [31:0] w0, w1;

        vecs[0] = '{"nominal40", 0, 64'h0000_00A5_A5A5_A55A, 32'hDEADBEEF, 32'h12000000,
                    0, 0, 0, 64'h0000_00DE_ADBE_EF12, 32'hA5A5A5A5, 32'h5A000000};
        vecs[1] = '{"stall40", 0, 64'h0000_00A5_A5A5_A55A, 32'hDEADBEEF, 32'h12000000,
                    5, 0, 0, 64'h0000_00DE_ADBE_EF12, 32'hA5A5A5A5, 32'h5A000000};
        vecs[2] = '{"exact64", 1, 64'h0123_4567_89AB_CDEF, 32'hCAFEF00D, 32'h13579BDF,
                    0, 0, 0, 64'hCAFE_F00D_1357_9BDF, 32'h01234567, 32'h89ABCDEF};
        vecs[3] = '{"backpr64", 1, 64'hFEDC_BA98_7654_3210, 32'h0F0F0F0F, 32'hF0F0F0F1,
                    0, 10, 0, 64'h0F0F_0F0F_F0F0_F0F1, 32'hFEDCBA98, 32'h76543210};
        vecs[4] = '{"restart40", 0, 64'h0000_00A5_A5A5_A55A, 32'hDEADBEEF, 32'h12FFFFFF,
                    0, 0, 10, 64'h0000_00DE_ADBE_EF12, 32'hA5A5A5A5, 32'h5A000000};

        prog_reset = 1'b1;
        start_s = '0; cfg_valid_s = '0; rb_ready_s = '1; pre_load = '0;
        cfg_data_s = '0; pre_val = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {52'd0, cfg_ready_s, head_s, en_s, rb_valid_s, busy_s, done_s}, 64'd0);
        check("reset_rb_data", {rb_data_s[1], rb_data_s[0]}, 64'd0);
        prog_reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_load(vecs[v].tag, vecs[v].inst, vecs[v].pre, vecs[v].w0, vecs[v].w1,
                     vecs[v].exp_chain, vecs[v].exp_rb0, vecs[v].exp_rb1,
                     vecs[v].gap, vecs[v].hold, vecs[v].restart_at, 1'b0);
        end

        // Reset in the middle of a load, after bit 17 has entered the chain.
        @(negedge clk);
        pre_load[0] = 1'b1; pre_val[0] = 64'h0000_00A5_A5A5_A55A;
        @(negedge clk);
        pre_load[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; cfg_data_s[0] = 32'hDEADBEEF; cfg_valid_s[0] = 1'b1;
        cyc = 0;
        while (en_cnt[0] < 17 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid:reach17", 64'(en_cnt[0]), 64'd17);
        prog_reset = 1'b1;
        @(negedge clk);
        check("rstmid:ctrl", {58'd0, cfg_ready_s[0], head_s[0], en_s[0], rb_valid_s[0],
                              busy_s[0], done_s[0]}, 64'd0);
        check("rstmid:rb_data", 64'(rb_data_s[0]), 64'd0);
        prog_reset = 1'b0; cfg_valid_s[0] = 1'b0;
        run_load("after_rst", 0, 64'h0000_0011_2233_4455, 32'h89ABCDEF, 32'h76000000,
                 64'h0000_0089_ABCD_EF76, 32'h11223344, 32'h55000000, 0, 0, 0, 1'b0);

        // Randomized loads with random cfg_valid and rb_ready patterns.
        for (int r = 0; r < 16; r++) begin
            inst = int'($urandom_range(0, 1));
            len  = (inst == 0) ? LEN0 : LEN1;
            pre  = {$urandom, $urandom};
            w0   = $urandom;
            w1   = $urandom;
            exp_chain = {w0, w1} >> (64 - len);
            left      = pre << (64 - len);
            run_load($sformatf("rand%0d", r), inst, pre, w0, w1, exp_chain,
                     left[63:32], left[31:0], 0, 0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
